// File: rtl/arb_grant_mux_if.sv
// Stream bundle between the priority arbiter, the client data streams and
// the shared downstream master stream of arb_grant_mux.
//
// Signals:
//   arb_id  [BITW:0]       {vld,id} grant from the arbiter (MSB is vld)
//   s_valid [WIDTH-1:0]    per-client beat valid
//   s_last  [WIDTH-1:0]    per-client last beat
//   s_data  [WIDTH*DATW-1:0] per-client data, client k at [k*DATW +: DATW]
//   s_ready [WIDTH-1:0]    one-hot ready to the owning client
//   m_valid/m_data/m_id/m_last  registered output beat
//   m_ready                downstream ready
//   done    [WIDTH-1:0]    one-cycle one-hot release pulse
//   busy                   ownership locked
//   err                    one-cycle watchdog abort pulse
//
// Modports:
//   master : the mux itself (drives the shared stream and client readies)
//   slave  : the environment (arbiter, clients, downstream sink)
interface arb_grant_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DATW  = 32,
  parameter int unsigned BITW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic [BITW:0]         arb_id;
  logic [WIDTH-1:0]      s_valid;
  logic [WIDTH-1:0]      s_last;
  logic [WIDTH*DATW-1:0] s_data;
  logic [WIDTH-1:0]      s_ready;
  logic                  m_valid;
  logic [DATW-1:0]       m_data;
  logic [BITW-1:0]       m_id;
  logic                  m_last;
  logic                  m_ready;
  logic [WIDTH-1:0]      done;
  logic                  busy;
  logic                  err;

  modport master (
    input  arb_id, s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_data, m_id, m_last, done, busy, err
  );

  modport slave (
    output arb_id, s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_id, m_last, done, busy, err
  );
endinterface

// File: rtl/arb_grant_mux.sv
// arb_grant_mux: consumes the arbiter's {vld,id} grant, locks ownership to
// the granted client for one burst and routes that client's beats through a
// registered output stage onto the shared master stream. A burst ends on the
// client's last beat or after MAXLEN beats; once the final beat has left the
// output register, done[owner] pulses for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    arb_grant_mux_if.master (grant, client streams, shared stream,
//          done/busy/err status)
//
// Optional feature: define ARB_MUX_TIMEOUT_EN to enable the idle-beat
// watchdog (TIMEOUT cycles without an accepted beat aborts the burst and
// pulses err). Without it err is tied to 0.
module arb_grant_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DATW    = 32,
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned BITW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input logic             clk,
  input logic             rst_n,
  arb_grant_mux_if.master bus
);

  localparam int unsigned CNTW = $clog2(MAXLEN) + 1;

  typedef enum logic [1:0] {IDLE, XFER, REL} state_t;

  state_t          state;
  logic [BITW-1:0] owner;
  logic [CNTW-1:0] cnt;

  logic            out_free;
  logic            sel_valid;
  logic            sel_last;
  logic [DATW-1:0] sel_data;
  logic            accept;
  logic            last_in;
  logic            id_ok;

`ifdef ARB_MUX_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    out_free  = !bus.m_valid || bus.m_ready;
    sel_valid = bus.s_valid[owner];
    sel_last  = bus.s_last[owner];
    sel_data  = bus.s_data[int'(owner) * DATW +: DATW];
    accept    = (state == XFER) && sel_valid && out_free;
    last_in   = sel_last || (cnt == CNTW'(MAXLEN - 1));
    // Zero-extend both sides so a non-power-of-two WIDTH rejects ids past the end.
    id_ok     = {1'b0, bus.arb_id[BITW-1:0]} < (BITW + 1)'(WIDTH);
  end

  // Ready follows the output register's space, so it is combinational from
  // registered state and m_ready only.
  always_comb begin
    bus.s_ready = '0;
    if (state == XFER) bus.s_ready[owner] = out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      cnt         <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_id    <= '0;
      bus.m_last  <= 1'b0;
      bus.done    <= '0;
      bus.busy    <= 1'b0;
`ifdef ARB_MUX_TIMEOUT_EN
      bus.err     <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      bus.done <= '0;
`ifdef ARB_MUX_TIMEOUT_EN
      bus.err  <= 1'b0;
`endif

      // Output register: load on accept, otherwise drain when taken.
      if (accept) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= sel_data;
        bus.m_id    <= owner;
        bus.m_last  <= last_in;
        cnt         <= cnt + 1'b1;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.arb_id[BITW] && id_ok) begin
            owner    <= bus.arb_id[BITW-1:0];
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= XFER;
`ifdef ARB_MUX_TIMEOUT_EN
            wdog     <= '0;
`endif
          end
        end
        XFER: begin
          if (accept && last_in) state <= REL;
`ifdef ARB_MUX_TIMEOUT_EN
          if (accept) begin
            wdog <= '0;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            wdog    <= '0;
            bus.err <= 1'b1;
            state   <= REL;
            // A beat still stuck in the output register becomes the burst end.
            if (bus.m_valid && !bus.m_ready) bus.m_last <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        REL: begin
          if (out_free) begin
            bus.done[owner] <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_grant_mux.sv
module tb_arb_grant_mux;

  localparam int WIDTH = 32;
  localparam int DATW  = 32;
  localparam int BITW  = 5;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  id;
    logic        last;
  } beat_t;

  logic clk;
  logic rst_n;

  arb_grant_mux_if #(.WIDTH(WIDTH), .DATW(DATW), .BITW(BITW)) bus ();

  arb_grant_mux #(
    .WIDTH(WIDTH), .DATW(DATW), .MAXLEN(16), .TIMEOUT(64), .BITW(BITW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  int    done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_burst(input int id, input logic [31:0] base, input int n, input int last_at);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = 32'(base + i);
      b.id   = 5'(id);
      b.last = (i == last_at);
      exp_q.push_back(b);
    end
    done_q.push_back(id);
  endtask

  // Scoreboard monitor: compares every beat leaving the output register and
  // every done pulse against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.m_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.m_data), 64'(e.data));
          check("beat_id",   64'(bus.m_id),   64'(e.id));
          check("beat_last", 64'(bus.m_last), 64'(e.last));
        end
      end
      if (bus.m_valid && !bus.m_ready)
        check("stall_s_ready", 64'(bus.s_ready), 64'd0);
      if (bus.done != '0) begin
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done actual=%0h required=0", bus.done);
        end else begin
          int d;
          d = done_q.pop_front();
          check("done_onehot", 64'(bus.done), 64'(1) << d);
        end
      end
`ifndef ARB_MUX_TIMEOUT_EN
      if (bus.err !== 1'b0) check("err_tied", 64'(bus.err), 64'd0);
`endif
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic grant(input int id);
    align();
    bus.arb_id = {1'b1, 5'(id)};
    align();
    bus.arb_id = '0;
  endtask

  // Presents beats from client k; call at posedge+1. Returns beats accepted.
  task automatic send(input int k, input int n, input logic [31:0] base, input int last_at,
                      input int budget, output int acc);
    int   i;
    int   cyc;
    logic hs;
    i = 0; cyc = 0; acc = 0;
    while (i < n && cyc < budget) begin
      bus.s_valid[k] = 1'b1;
      bus.s_data[k*DATW +: DATW] = 32'(base + i);
      bus.s_last[k] = (i == last_at);
      @(negedge clk);
      hs = bus.s_ready[k];
      align();
      cyc++;
      if (hs) begin
        i++;
        acc++;
      end
    end
    bus.s_valid[k] = 1'b0;
    bus.s_last[k]  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int acc;
    int cyc;
    bus.arb_id  = '0;
    bus.s_valid = '0;
    bus.s_last  = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    check("rst_done",    64'(bus.done),    64'd0);
    check("rst_m_data",  64'(bus.m_data),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single burst: client 5, 0xA0..0xA3, last on beat 4
    push_burst(5, 32'hA0, 4, 3);
    grant(5);
    check("single_busy", 64'(bus.busy), 64'd1);
    send(5, 4, 32'hA0, 3, 20, acc);
    check("single_accepted", 64'(acc), 64'd4);
    wait_done(10, cyc);
    check("single_done_lat", 64'(cyc), 64'd2);
    check("single_busy_off", 64'(bus.busy), 64'd0);

    // Back-pressure: m_ready low for 3 cycles mid-burst
    push_burst(4, 32'h40, 6, 5);
    grant(4);
    fork
      send(4, 6, 32'h40, 5, 30, acc);
      begin
        repeat (2) @(posedge clk);
        #1 bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.m_ready = 1'b1;
      end
    join
    check("bp_accepted", 64'(acc), 64'd6);
    wait_done(10, cyc);
    check("bp_done_lat", 64'(cyc), 64'd2);

    // Truncation: 20 beats with no last, only 16 taken
    push_burst(9, 32'h900, 16, 15);
    grant(9);
    send(9, 20, 32'h900, -1, 30, acc);
    check("trunc_accepted", 64'(acc), 64'd16);
    check("trunc_busy", 64'(bus.busy), 64'd0);
    check("trunc_s_ready", 64'(bus.s_ready), 64'd0);

    // Lock stability: arbiter moves from 7 to 2 mid-burst
    push_burst(7, 32'h70, 4, 3);
    align();
    bus.arb_id = {1'b1, 5'd7};
    align();
    fork
      send(7, 4, 32'h70, 3, 20, acc);
      begin
        repeat (2) @(posedge clk);
        #1 bus.arb_id = {1'b1, 5'd2};
      end
    join
    check("lock_accepted", 64'(acc), 64'd4);
    wait_done(10, cyc);
    check("lock_done_lat", 64'(cyc), 64'd2);
    @(negedge clk);
    check("lock_next_s_ready", 64'(bus.s_ready), 64'h4);
    check("lock_next_busy", 64'(bus.busy), 64'd1);
    push_burst(2, 32'hC0, 2, 1);
    align();
    bus.arb_id = '0;
    send(2, 2, 32'hC0, 1, 20, acc);
    check("lock2_accepted", 64'(acc), 64'd2);
    wait_done(10, cyc);
    check("lock2_done_lat", 64'(cyc), 64'd2);

    // Reset mid-burst: client 3, reset after 2 of 5 beats; only beat 1 leaves
    exp_q.push_back('{data: 32'h30, id: 5'd3, last: 1'b0});
    grant(3);
    send(3, 2, 32'h30, -1, 10, acc);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("mid_rst_m_data",  64'(bus.m_data),  64'd0);
    check("mid_rst_m_id",    64'(bus.m_id),    64'd0);
    check("mid_rst_m_last",  64'(bus.m_last),  64'd0);
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("mid_rst_busy",    64'(bus.busy),    64'd0);
    check("mid_rst_done",    64'(bus.done),    64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

`ifdef ARB_MUX_TIMEOUT_EN
    // Watchdog: client 6 stalls after beat 2 while beat 2 is held downstream
    exp_q.push_back('{data: 32'h60, id: 5'd6, last: 1'b0});
    exp_q.push_back('{data: 32'h61, id: 5'd6, last: 1'b1});
    done_q.push_back(6);
    grant(6);
    send(6, 2, 32'h60, -1, 10, acc);
    bus.m_ready = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.err) begin
        cyc = k;
        break;
      end
    end
    check("wdog_err_lat", 64'(cyc), 64'd65);
    align();
    bus.m_ready = 1'b1;
    wait_done(10, cyc);
    check("wdog_done_lat", 64'(cyc), 64'd2);
    check("wdog_busy_off", 64'(bus.busy), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("exp_q_empty",  64'(exp_q.size()),  64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_grant_mux.md
Name: arb_grant_mux

Overview:
- Downstream stage of the priority arbiter: consumes the arbiter's {vld,id} grant and routes the granted client's data stream onto one shared master stream.
- Locks ownership for the duration of a burst so a priority change mid-burst cannot cut a transfer.
- Registers the output so the shared path gets valid/ready back-pressure.
- Pulses a release indication when the burst completes, so the client can drop its request.

Parameters:
- WIDTH, 32, number of clients; matches the arbiter WIDTH.
- DATW, 32, data width per client.
- MAXLEN, 16, maximum beats per burst; the block forces last at this count.
- TIMEOUT, 64, idle-beat watchdog limit; used only with ARB_MUX_TIMEOUT_EN.
- BITW, log2(WIDTH), derived id width; log2 means the smallest n with 2**n >= WIDTH.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  clock, rising edge
- arb_id  in  BITW+1  {vld,id} from the arbiter; MSB is vld
- s_valid  in  WIDTH  per-client beat valid
- s_last  in  WIDTH  per-client last beat
- s_data  in  WIDTH*DATW  per-client data, flattened; client k occupies [k*DATW +: DATW]
- s_ready  out  WIDTH  one-hot ready to the owning client
- m_valid  out  1  output beat valid (registered)
- m_data  out  DATW  output data (registered)
- m_id  out  BITW  owner id of the output beat
- m_last  out  1  last beat of burst
- m_ready  in  1  downstream ready
- done  out  WIDTH  one-cycle one-hot release pulse to the owning client
- busy  out  1  high while ownership is locked
- err  out  1  one-cycle watchdog abort pulse (constant 0 without the macro)

Behaviour:
- Reset (asynchronous, any time, including mid-burst): state=IDLE; owner=0; cnt=0; s_ready, m_valid, m_data, m_id, m_last, done, busy and err all 0. Any in-flight beat is discarded.
- States: IDLE, XFER, REL.
- IDLE:
  - busy=0; s_ready=0.
  - If arb_id[BITW]=1, latch owner=arb_id[BITW-1:0], clear cnt and go to XFER on the next edge.
  - If the id is >= WIDTH, ignore it and stay in IDLE.
- XFER:
  - busy=1.
  - s_ready[owner] = !m_valid || m_ready; all other s_ready bits are 0.
  - Arbiter changes on arb_id are ignored while locked.
- Beat acceptance: s_valid[owner] && s_ready[owner]. On acceptance:
  - m_data <= s_data[owner]; m_id <= owner; m_valid <= 1.
  - m_last <= s_last[owner] || (cnt==MAXLEN-1).
  - cnt <= cnt+1.
- Output register: m_valid clears when m_ready=1 and no new beat is accepted in the same cycle. m_data, m_id and m_last hold while m_valid && !m_ready. Simultaneous accept-in and accept-out gives full throughput, one beat per cycle.
- Latency: 1 cycle from client beat to m_valid.
- Burst end:
  - When a beat with m_last=1 is accepted into the output register, s_ready drops from the next cycle and the state goes to REL.
  - At MAXLEN the burst is truncated. The client must re-request for the remainder.
- REL:
  - Wait until the last beat leaves the output register (m_valid && m_ready, or m_valid already 0).
  - Then pulse done[owner] for 1 cycle and go to IDLE.
  - The earliest new lock is the cycle after done.
- Back-to-back: a burst from client A, then client B, has a minimum gap of 2 cycles between A's last beat out and B's first s_ready.
- cnt width is log2(MAXLEN)+1; it never exceeds MAXLEN.

Optional Feature:
- Macro: ARB_MUX_TIMEOUT_EN.
- Defined:
  - A watchdog counter increments each XFER cycle with no accepted beat and clears on acceptance.
  - When it reaches TIMEOUT, err pulses for 1 cycle and the burst aborts.
  - Abort with m_valid=1: the pending beat is marked m_last=1, then the block goes to REL.
  - Abort with m_valid=0: the block goes directly to REL.
- Undefined: no watchdog logic; err is tied to 0; a stalled client holds the lock indefinitely.

Test Plan:
- Reset mid-burst: owner=3, deassert rst_n after 2 of 5 beats -> all outputs 0 immediately; state IDLE; no done pulse.
- Single burst: arb_id={1,5}, client 5 sends 4 beats 0xA0..0xA3 with last on the 4th, m_ready=1 -> m_data 0xA0..0xA3 on 4 consecutive cycles, each 1 cycle after input; m_id=5; m_last on beat 4; done[5] pulses 1 cycle later.
- Back-pressure: m_ready=0 for 3 cycles mid-burst -> m_data holds; s_ready[owner]=0 while m_valid=1; no beat lost or duplicated.
- Truncation: MAXLEN=16, client sends 20 beats with no last -> m_last on beat 16; done pulses; beats 17-20 are not accepted.
- Lock stability: the arbiter switches arb_id from 7 to 2 mid-burst -> owner stays 7 until done[7]; then client 2 is locked the cycle after done.
- With ARB_MUX_TIMEOUT_EN, TIMEOUT=64: the client stalls after beat 2 -> err pulses at 64 idle cycles; pending beat flagged m_last; done pulses; state returns to IDLE.
